// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of an LSB-first serialiser.
// State table:
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) held one bit time
//   DATA  | eight data bits, LSB first, one bit time each
//   STOP  | stop bit (high); pops the next byte straight into START if one is queued
module uart_tx_buffered #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 38400,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               tx_data,
  input  logic                     tx_wr,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic                     tx_idle,
  output logic                     tx_ovf,
  input  logic                     ovf_clr,
  output logic                     uart_txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DIV - 1);
  localparam logic [LW-1:0] FULL       = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [2:0]      bitcnt, bitcnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            txd_n;
  logic            pop;
  logic            push;
  logic            drop;
  logic            fifo_nonempty;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_n;

  // Occupancy is judged before the edge, so a concurrent pop never makes room for a write.
  assign fifo_nonempty = (tx_level != '0);
  assign push          = tx_wr && (tx_level != FULL);
  assign drop          = tx_wr && (tx_level == FULL);
  assign level_n       = tx_level + LW'(push) - LW'(pop);

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    txd_n    = uart_txd;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          txd_n   = 1'b0;
          timer_n = TIMER_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (timer == '0) begin
          txd_n    = shreg[0];
          bitcnt_n = '0;
          timer_n  = TIMER_LOAD;
          state_n  = DATA;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_n = TIMER_LOAD;
          if (bitcnt == 3'd7) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            bitcnt_n = bitcnt + 3'd1;
            shreg_n  = {1'b0, shreg[7:1]};
            txd_n    = shreg[1];
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      STOP: begin
        if (timer == '0) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            txd_n   = 1'b0;
            timer_n = TIMER_LOAD;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      uart_txd <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_level <= '0;
      tx_busy  <= 1'b0;
      tx_idle  <= 1'b1;
      tx_ovf   <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bitcnt   <= bitcnt_n;
      shreg    <= shreg_n;
      uart_txd <= txd_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      tx_level <= level_n;
      tx_busy  <= (level_n == FULL);
      tx_idle  <= (state_n == IDLE) && (level_n == '0);
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)         tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered (DIV=8, DEPTH=4): a line monitor decodes every frame
// and checks it against a queue of bytes expected in FIFO order.
module tb_uart_tx_buffered;

  localparam int DIV   = 8;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic [2:0] tx_level;
  logic       tx_idle;
  logic       tx_ovf;
  logic       ovf_clr;
  logic       uart_txd;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int frames_done = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];

  uart_tx_buffered #(.CLK_FREQ(80), .BAUD(10), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy),
    .tx_level (tx_level),
    .tx_idle  (tx_idle),
    .tx_ovf   (tx_ovf),
    .ovf_clr  (ovf_clr),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    step();
    tx_wr   = 1'b0;
  endtask

  // Line monitor: every sample of a frame must match the ideal waveform of the expected byte.
  initial begin
    logic [7:0] want;
    logic [7:0] rx;
    logic       expb;
    int         mism;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!reset && uart_txd === 1'b0) begin
        start_cyc.push_back(cyc);
        check("frame_expected", exp_q.size() > 0, 1);
        want    = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        mism    = 0;
        rx      = 8'h00;
        aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (i < DIV)                 expb = 1'b0;
          else if (i >= FRAME - DIV)   expb = 1'b1;
          else                         expb = want[i / DIV - 1];
          if (uart_txd !== expb) mism++;
          if (i % DIV == DIV / 2 && i >= DIV && i < FRAME - DIV) rx[i / DIV - 1] = uart_txd;
        end
        if (!aborted) begin
          frames_done++;
          check("frame_timing", mism, 0);
          check("frame_data", rx, want);
        end
      end
    end
  end

  initial begin
    logic [7:0] t2 [3];
    int f0;
    int lows;
    t2 = '{8'h55, 8'h0F, 8'hF0};
    reset   = 1'b1;
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    ovf_clr = 1'b0;
    repeat (3) step();
    check("reset_txd", uart_txd, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_level", tx_level, 0);
    check("reset_idle", tx_idle, 1);
    check("reset_ovf", tx_ovf, 0);
    reset = 1'b0;
    repeat (2) step();

    // single byte from idle
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    check("t1_level_after_wr", tx_level, 1);
    check("t1_idle_after_wr", tx_idle, 0);
    check("t1_txd_before_pop", uart_txd, 1);
    step();
    check("t1_txd_start", uart_txd, 0);
    check("t1_level_after_pop", tx_level, 0);
    repeat (FRAME - 1) step();
    check("t1_stop_bit", uart_txd, 1);
    check("t1_idle_last_stop", tx_idle, 0);
    step();
    check("t1_idle_end", tx_idle, 1);
    repeat (4) step();

    // back-to-back frames
    start_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(t2[k]);
      wr(t2[k]);
    end
    check("t2_level", tx_level, 2);
    repeat (FRAME - 2) step();
    check("t2_level_pre_pop", tx_level, 2);
    step();
    check("t2_level_post_pop", tx_level, 1);
    check("t2_txd_no_gap", uart_txd, 0);
    repeat (170) step();
    check("t2_idle", tx_idle, 1);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_frames", start_cyc.size(), 3);
    check("t2_gap_1", start_cyc[1] - start_cyc[0], FRAME);
    check("t2_gap_2", start_cyc[2] - start_cyc[1], FRAME);

    // overflow: 6 writes on consecutive clocks, then drops at the STOP->START pop
    f0 = frames_done;
    exp_q.push_back(8'h11); wr(8'h11);
    exp_q.push_back(8'h22); wr(8'h22);
    exp_q.push_back(8'h33); wr(8'h33);
    exp_q.push_back(8'h44); wr(8'h44);
    exp_q.push_back(8'h66); wr(8'h66);
    check("t3_busy_full", tx_busy, 1);
    check("t3_level_full", tx_level, 4);
    check("t3_ovf_before_drop", tx_ovf, 0);
    wr(8'h77);
    check("t3_ovf_drop", tx_ovf, 1);
    check("t3_level_after_drop", tx_level, 4);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", tx_ovf, 0);
    repeat (74) step();
    check("t3_level_pre_pop", tx_level, 4);
    check("t3_txd_stop", uart_txd, 1);
    wr(8'h99);
    check("t3_level_drop_on_pop", tx_level, 3);
    check("t3_ovf_drop_on_pop", tx_ovf, 1);
    check("t3_busy_drop_on_pop", tx_busy, 0);
    check("t3_txd_next_start", uart_txd, 0);
    exp_q.push_back(8'h88);
    wr(8'h88);
    check("t3_level_refill", tx_level, 4);
    check("t3_busy_refill", tx_busy, 1);
    tx_data = 8'h9A;
    tx_wr   = 1'b1;
    ovf_clr = 1'b1;
    step();
    tx_wr   = 1'b0;
    ovf_clr = 1'b0;
    check("t3_ovf_set_wins", tx_ovf, 1);
    check("t3_level_set_wins", tx_level, 4);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr_2", tx_ovf, 0);
    repeat (400) step();
    check("t3_frames", frames_done - f0, 6);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_idle", tx_idle, 1);

    // reset mid-frame with bytes queued
    f0 = frames_done;
    exp_q.push_back(8'hC3); wr(8'hC3);
    exp_q.push_back(8'hD2); wr(8'hD2);
    exp_q.push_back(8'hE1); wr(8'hE1);
    repeat (33) step();
    check("t4_level_pre_reset", tx_level, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("t4_txd_after_reset", uart_txd, 1);
    check("t4_level_after_reset", tx_level, 0);
    check("t4_idle_after_reset", tx_idle, 1);
    check("t4_busy_after_reset", tx_busy, 0);
    lows = 0;
    repeat (100) begin
      step();
      if (uart_txd !== 1'b1) lows++;
    end
    check("t4_line_quiet", lows, 0);
    check("t4_no_frames", frames_done - f0, 0);
    exp_q.push_back(8'h5A);
    wr(8'h5A);
    repeat (90) step();
    check("t4_new_frame", frames_done - f0, 1);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_idle", tx_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
